tpu_tile_scheduler: RTL and testbench
=====================================

# tpu_tile_scheduler

Sequences a K×M×N int8 GEMM over the 4×4 systolic-array engine, one output tile at a time. It latches the problem dimensions and walks all (m, n) tiles: m is the inner loop over 4-row blocks of A/C, n is the outer loop over 4-column blocks of B/C. For each tile it issues a command (A/B/C base indices, valid row and column counts, K length) to the compute engine over a valid/ready handshake, then waits for the engine's completion pulse. It sits between the host-facing start interface and the array datapath, replacing ad-hoc tile stepping inside the compute FSM.

## Interface
- TILE, 4, systolic array edge; tile rows and columns.
- IDX_W, 12, buffer index width.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- in_valid  in  1  start pulse; sampled only when busy=0.
- K, M, N  in  8 each  dimensions, unsigned, latched on accepted in_valid.
- busy  out  1  high from accept until the cycle done pulses.
- done  out  1  one-cycle pulse at job end.
- tile_valid  out  1  command valid.
- tile_ready  in  1  engine accepts the command.
- tile_a_base  out  IDX_W  m·K (A index of k=0).
- tile_b_base  out  IDX_W  n·K.
- tile_c_base  out  IDX_W  n·M + 4·m.
- tile_rows  out  3  min(4, M−4m), range 1..4.
- tile_cols  out  3  min(4, N−4n), range 1..4.
- tile_k  out  8  latched K.
- tile_last  out  1  this is the final tile of the job.
- tile_done  in  1  engine finished the outstanding tile (pulse).

## Operation
- States: IDLE, SETUP, ISSUE, WAIT, FINISH.
- IDLE: on in_valid, latch K/M/N and go to SETUP. in_valid while busy=1 is ignored.
- SETUP: compute Mt=ceil(M/4) and Nt=ceil(N/4). Clear m, n and all bases.
  - If K, M or N is 0, go to FINISH (no tiles issued).
  - Otherwise go to ISSUE.
- ISSUE: tile_valid=1. On tile_valid & tile_ready, go to WAIT. All tile_* fields are stable while valid is high and ready is low.
- WAIT: tile_valid=0. Ignore tile_ready. On tile_done:
  - If the tile was last, go to FINISH.
  - Else if m+1<Mt: m++, a_base+=K, c_base+=4, then ISSUE.
  - Else: m=0, n++, a_base=0, b_base+=K, c_row+=M, c_base=c_row, then ISSUE.
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- tile_done outside WAIT is ignored.
- All base arithmetic uses incremental adders, no multipliers, modulo 2^IDX_W (silent wrap).
- tile_rows = M−4m clamped to 4; tile_cols = N−4n clamped to 4. Both are registered with the bases.
- tile_last = (m==Mt−1) && (n==Nt−1).
- reset at any time: everything returns to IDLE; the outstanding tile is abandoned with no done pulse.
- Reset values: busy=0, done=0, tile_valid=0, tile_last=0; all tile_* fields 0.

## Timing
- in_valid accepted at cycle t → busy=1 at t+1; SETUP at t+1; first tile_valid at t+2.
- Zero dimension: busy=1 at t+1, done=1 and busy=0 at t+2.
- Handshake at cycle h → tile_valid=0 at h+1.
- tile_done at cycle d on a non-last tile → next tile_valid=1 at d+1, with updated fields.
- tile_done at cycle d on the last tile → done=1 and busy=0 at d+1. A new in_valid is accepted from d+1.
- tile_done in the same cycle as the handshake is ignored: the engine cannot finish before acceptance.

## Structure
- Shared package (tpu_pkg): TILE, IDX_W, the state enum, and a ceil_div4 function.
- One sub-module: tpu_tile_addr_gen, holding the m/n counters, the incremental a/b/c base registers, and the rows/cols/last logic. It is stepped by the FSM via `clear` and `step` strobes.

## Test plan
- K=M=N=4 → single tile: a=0, b=0, c=0, rows=4, cols=4, last=1. done pulses one cycle after tile_done.
- K=16, M=8, N=8 → four tiles in order (m,n) = (0,0),(1,0),(0,1),(1,1):
  - a_base = 0, 16, 0, 16
  - b_base = 0, 0, 16, 16
  - c_base = 0, 4, 8, 12
  - last=1 only on the fourth tile.
- K=3, M=6, N=5 → four tiles:
  - rows = 4, 2, 4, 2
  - cols = 4, 4, 1, 1
  - c_base = 0, 4, 6, 10
- tile_ready held low 5 cycles in ISSUE → tile_valid stays high and all fields are unchanged. A tile_done pulse during ISSUE is ignored.
- M=0 (K=N=4) → no tile_valid; busy high exactly one cycle, then a done pulse.
- in_valid during busy → ignored and dims unchanged. Then reset asserted in WAIT → the next cycle has busy=0, tile_valid=0, no done, and a fresh in_valid starts a clean job.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the tile scheduler slice.
// TILE     : systolic array edge (tile rows/columns).
// IDX_W    : buffer index width for A/B/C base indices.
// state_t  : scheduler FSM states.
// ceil_div4: number of 4-wide tiles needed to cover an 8-bit dimension.
package tpu_pkg;

    localparam int unsigned TILE  = 4;
    localparam int unsigned IDX_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    function automatic logic [6:0] ceil_div4(input logic [7:0] d);
        logic [8:0] s;
        s = {1'b0, d} + 9'd3;
        return s[8:2];
    endfunction

endpackage

// File: rtl/tpu_tile_scheduler_if.sv
// Host start/status and engine tile-command signals of the tile scheduler.
// master : scheduler side (drives busy/done and the tile command).
// slave  : host + engine side (drives start, dims, tile_ready, tile_done).
interface tpu_tile_scheduler_if;
    import tpu_pkg::*;

    logic             in_valid;
    logic [7:0]       K;
    logic [7:0]       M;
    logic [7:0]       N;
    logic             busy;
    logic             done;
    logic             tile_valid;
    logic             tile_ready;
    logic [IDX_W-1:0] tile_a_base;
    logic [IDX_W-1:0] tile_b_base;
    logic [IDX_W-1:0] tile_c_base;
    logic [2:0]       tile_rows;
    logic [2:0]       tile_cols;
    logic [7:0]       tile_k;
    logic             tile_last;
    logic             tile_done;

    modport master (
        input  in_valid, K, M, N, tile_ready, tile_done,
        output busy, done, tile_valid, tile_a_base, tile_b_base, tile_c_base,
               tile_rows, tile_cols, tile_k, tile_last
    );

    modport slave (
        output in_valid, K, M, N, tile_ready, tile_done,
        input  busy, done, tile_valid, tile_a_base, tile_b_base, tile_c_base,
               tile_rows, tile_cols, tile_k, tile_last
    );

endinterface

// File: rtl/tpu_tile_addr_gen.sv
// Tile walker: m/n tile counters, incremental A/B/C base registers and the
// registered rows/cols/last of the current tile.
// clk, reset          : clock, synchronous active-high reset
// clear               : restart the walk at tile (0,0) for the latched dims
// step                : advance to the next tile (m inner, n outer)
// k_dim, m_dim, n_dim : latched problem dimensions
// a_base/b_base/c_base: buffer indices of the current tile (mod 2^IDX_W)
// rows, cols, last    : valid rows/cols of the current tile, final-tile flag
module tpu_tile_addr_gen
    import tpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    input  logic [7:0]       k_dim,
    input  logic [7:0]       m_dim,
    input  logic [7:0]       n_dim,
    output logic [IDX_W-1:0] a_base,
    output logic [IDX_W-1:0] b_base,
    output logic [IDX_W-1:0] c_base,
    output logic [2:0]       rows,
    output logic [2:0]       cols,
    output logic             last
);

    logic [6:0]       mt, nt;
    logic [6:0]       m_idx, n_idx, m_nx, n_nx;
    logic [7:0]       rem_m, rem_n, rem_m_nx, rem_n_nx;
    logic [IDX_W-1:0] c_row, c_row_nx, a_nx, b_nx, c_nx;
    logic [IDX_W-1:0] k_ext, m_ext;

    assign mt    = ceil_div4(m_dim);
    assign nt    = ceil_div4(n_dim);
    assign k_ext = IDX_W'(k_dim);
    assign m_ext = IDX_W'(m_dim);

    function automatic logic [2:0] clamp_tile(input logic [7:0] r);
        return (r >= 8'(TILE)) ? 3'(TILE) : r[2:0];
    endfunction

    // rem_m/rem_n hold M-4m and N-4n so rows/cols need no multiply.
    always_comb begin
        m_nx     = m_idx;
        n_nx     = n_idx;
        a_nx     = a_base;
        b_nx     = b_base;
        c_nx     = c_base;
        c_row_nx = c_row;
        rem_m_nx = rem_m;
        rem_n_nx = rem_n;
        if (clear) begin
            m_nx     = '0;
            n_nx     = '0;
            a_nx     = '0;
            b_nx     = '0;
            c_nx     = '0;
            c_row_nx = '0;
            rem_m_nx = m_dim;
            rem_n_nx = n_dim;
        end else if (step) begin
            if (m_idx + 7'd1 < mt) begin
                m_nx     = m_idx + 7'd1;
                a_nx     = a_base + k_ext;
                c_nx     = c_base + IDX_W'(TILE);
                rem_m_nx = rem_m - 8'(TILE);
            end else begin
                m_nx     = '0;
                n_nx     = n_idx + 7'd1;
                a_nx     = '0;
                b_nx     = b_base + k_ext;
                c_row_nx = c_row + m_ext;
                c_nx     = c_row_nx;
                rem_m_nx = m_dim;
                rem_n_nx = rem_n - 8'(TILE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_idx  <= '0;
            n_idx  <= '0;
            a_base <= '0;
            b_base <= '0;
            c_base <= '0;
            c_row  <= '0;
            rem_m  <= '0;
            rem_n  <= '0;
            rows   <= '0;
            cols   <= '0;
            last   <= 1'b0;
        end else begin
            m_idx  <= m_nx;
            n_idx  <= n_nx;
            a_base <= a_nx;
            b_base <= b_nx;
            c_base <= c_nx;
            c_row  <= c_row_nx;
            rem_m  <= rem_m_nx;
            rem_n  <= rem_n_nx;
            rows   <= clamp_tile(rem_m_nx);
            cols   <= clamp_tile(rem_n_nx);
            last   <= (m_nx == mt - 7'd1) && (n_nx == nt - 7'd1);
        end
    end

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Walks all (m, n) output tiles of a KxMxN int8 GEMM, issuing one command per
// tile to the systolic engine and waiting for its completion pulse.
// clk   : single clock, rising edge
// reset : synchronous, active-high
// bus   : start/dims in, busy/done out, tile command valid/ready + tile_done
module tpu_tile_scheduler
    import tpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    tpu_tile_scheduler_if.master bus
);

    state_t     state;
    logic [7:0] k_q, m_q, n_q;
    logic       clear, step;

    assign clear      = (state == SETUP);
    // The final tile never steps the walker; FINISH follows instead.
    assign step       = (state == WAIT) && bus.tile_done && !bus.tile_last;
    assign bus.tile_k = k_q;

    tpu_tile_addr_gen u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .step   (step),
        .k_dim  (k_q),
        .m_dim  (m_q),
        .n_dim  (n_q),
        .a_base (bus.tile_a_base),
        .b_base (bus.tile_b_base),
        .c_base (bus.tile_c_base),
        .rows   (bus.tile_rows),
        .cols   (bus.tile_cols),
        .last   (bus.tile_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.tile_valid <= 1'b0;
            k_q            <= '0;
            m_q            <= '0;
            n_q            <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                // busy is already low in FINISH, so a new job may start there.
                IDLE, FINISH: begin
                    state <= IDLE;
                    if (bus.in_valid) begin
                        k_q      <= bus.K;
                        m_q      <= bus.M;
                        n_q      <= bus.N;
                        bus.busy <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (k_q == 8'd0 || m_q == 8'd0 || n_q == 8'd0) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= FINISH;
                    end else begin
                        bus.tile_valid <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.tile_ready) begin
                        bus.tile_valid <= 1'b0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.tile_done) begin
                        if (bus.tile_last) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            bus.tile_valid <= 1'b1;
                            state          <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Testbench for tpu_tile_scheduler: directed tile tables, hand-written corner
// sequences, and random jobs checked against a nested-loop reference model.
module tb_tpu_tile_scheduler;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tpu_tile_scheduler_if bus ();

    tpu_tile_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit first;
        int k, m, n;
        int a, b, c, rows, cols;
        bit last;
    } exp_t;

    exp_t tbl[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fields(input exp_t e);
        check("a_base", int'(bus.tile_a_base), e.a);
        check("b_base", int'(bus.tile_b_base), e.b);
        check("c_base", int'(bus.tile_c_base), e.c);
        check("rows",   int'(bus.tile_rows),   e.rows);
        check("cols",   int'(bus.tile_cols),   e.cols);
        check("tile_k", int'(bus.tile_k),      e.k);
        check("last",   int'(bus.tile_last),   int'(e.last));
    endtask

    // Leaves the DUT in SETUP (one cycle after acceptance).
    task automatic start_job(input int k, input int m, input int n);
        bus.in_valid = 1'b1;
        bus.K = 8'(k);
        bus.M = 8'(m);
        bus.N = 8'(n);
        tick();
        bus.in_valid = 1'b0;
        check("busy_t1", int'(bus.busy), 1);
        check("done_t1", int'(bus.done), 0);
    endtask

    // One tile: optional ready stall (with an ignored tile_done), handshake,
    // WAIT delay, completion. Returns in FINISH after the last tile.
    task automatic do_tile(input exp_t e, input int unsigned rdly, input int unsigned ddly,
                           input bit done_in_issue, input bit done_at_hs);
        int unsigned w = 0;
        while (bus.tile_valid !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        check("tile_valid_up", int'(bus.tile_valid), 1);
        check_fields(e);
        for (int unsigned i = 0; i < rdly; i++) begin
            bus.tile_done = done_in_issue && (i == 0);
            tick();
            bus.tile_done = 1'b0;
            check("hold_valid", int'(bus.tile_valid), 1);
            check("hold_done", int'(bus.done), 0);
            check_fields(e);
        end
        bus.tile_ready = 1'b1;
        bus.tile_done  = done_at_hs;
        tick();
        bus.tile_ready = 1'b0;
        bus.tile_done  = 1'b0;
        check("valid_drop", int'(bus.tile_valid), 0);
        check("busy_wait", int'(bus.busy), 1);
        for (int unsigned i = 0; i < ddly; i++) begin
            bus.tile_ready = 1'($urandom_range(0, 1));
            tick();
            check("wait_valid", int'(bus.tile_valid), 0);
            check("wait_done", int'(bus.done), 0);
        end
        bus.tile_ready = 1'b0;
        bus.tile_done  = 1'b1;
        tick();
        bus.tile_done  = 1'b0;
        if (e.last) begin
            check("done_pulse", int'(bus.done), 1);
            check("busy_end", int'(bus.busy), 0);
            check("valid_end", int'(bus.tile_valid), 0);
        end else begin
            check("next_valid", int'(bus.tile_valid), 1);
            check("next_done", int'(bus.done), 0);
        end
    endtask

    task automatic finish_idle();
        tick();
        check("done_once", int'(bus.done), 0);
        check("busy_idle", int'(bus.busy), 0);
    endtask

    // Reference: every (m, n) tile of the job in order, m innermost.
    task automatic run_model_job(input int k, input int m, input int n);
        int   mt, nt;
        exp_t e;
        mt = (m + 3) / 4;
        nt = (n + 3) / 4;
        start_job(k, m, n);
        tick();
        if (k == 0 || m == 0 || n == 0) begin
            check("zero_done", int'(bus.done), 1);
            check("zero_busy", int'(bus.busy), 0);
            check("zero_valid", int'(bus.tile_valid), 0);
            return;
        end
        check("first_valid_t2", int'(bus.tile_valid), 1);
        for (int ni = 0; ni < nt; ni++) begin
            for (int mi = 0; mi < mt; mi++) begin
                e.first = (mi == 0 && ni == 0);
                e.k     = k;
                e.m     = m;
                e.n     = n;
                e.a     = (mi * k) % 4096;
                e.b     = (ni * k) % 4096;
                e.c     = (ni * m + 4 * mi) % 4096;
                e.rows  = (m - 4 * mi > 4) ? 4 : m - 4 * mi;
                e.cols  = (n - 4 * ni > 4) ? 4 : n - 4 * ni;
                e.last  = (mi == mt - 1) && (ni == nt - 1);
                do_tile(e, $urandom_range(0, 3), $urandom_range(0, 3),
                        ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.K          = '0;
        bus.M          = '0;
        bus.N          = '0;
        bus.tile_ready = 1'b0;
        bus.tile_done  = 1'b0;

        //         first  k   m  n   a   b   c  rows cols last
        tbl[0] = '{1'b1,  4,  4, 4,  0,  0,  0, 4,   4,   1'b1};
        tbl[1] = '{1'b1, 16,  8, 8,  0,  0,  0, 4,   4,   1'b0};
        tbl[2] = '{1'b0, 16,  8, 8, 16,  0,  4, 4,   4,   1'b0};
        tbl[3] = '{1'b0, 16,  8, 8,  0, 16,  8, 4,   4,   1'b0};
        tbl[4] = '{1'b0, 16,  8, 8, 16, 16, 12, 4,   4,   1'b1};
        tbl[5] = '{1'b1,  3,  6, 5,  0,  0,  0, 4,   4,   1'b0};
        tbl[6] = '{1'b0,  3,  6, 5,  3,  0,  4, 2,   4,   1'b0};
        tbl[7] = '{1'b0,  3,  6, 5,  0,  3,  6, 4,   1,   1'b0};
        tbl[8] = '{1'b0,  3,  6, 5,  3,  3, 10, 2,   1,   1'b1};

        repeat (3) tick();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_valid", int'(bus.tile_valid), 0);
        check("rst_last", int'(bus.tile_last), 0);
        check("rst_a", int'(bus.tile_a_base), 0);
        check("rst_c", int'(bus.tile_c_base), 0);
        check("rst_rows", int'(bus.tile_rows), 0);
        check("rst_k", int'(bus.tile_k), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].first) begin
                start_job(tbl[i].k, tbl[i].m, tbl[i].n);
                tick();
                check("tbl_first_valid", int'(bus.tile_valid), 1);
            end
            do_tile(tbl[i], i % 3, i % 2, 1'b0, 1'b0);
            if (tbl[i].last) finish_idle();
        end

        // Ready held low 5 cycles with a stray tile_done, then back-to-back M=0 job.
        start_job(4, 4, 4);
        tick();
        do_tile(tbl[0], 5, 0, 1'b1, 1'b0);
        start_job(4, 0, 4);
        tick();
        check("m0_done", int'(bus.done), 1);
        check("m0_busy", int'(bus.busy), 0);
        check("m0_valid", int'(bus.tile_valid), 0);
        finish_idle();

        // in_valid while busy is ignored; reset in WAIT abandons the tile.
        start_job(16, 8, 8);
        tick();
        bus.in_valid = 1'b1;
        bus.K = 8'd2;
        bus.M = 8'd2;
        bus.N = 8'd2;
        tick();
        bus.in_valid = 1'b0;
        check_fields(tbl[1]);
        check("busy_ign_valid", int'(bus.tile_valid), 1);
        bus.tile_ready = 1'b1;
        tick();
        bus.tile_ready = 1'b0;
        check("hs_wait_valid", int'(bus.tile_valid), 0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("wait_busy", int'(bus.busy), 1);
        check("wait_k_kept", int'(bus.tile_k), 16);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_busy", int'(bus.busy), 0);
        check("rw_valid", int'(bus.tile_valid), 0);
        check("rw_done", int'(bus.done), 0);
        check("rw_last", int'(bus.tile_last), 0);
        check("rw_b", int'(bus.tile_b_base), 0);
        tick();
        check("rw_done2", int'(bus.done), 0);
        run_model_job(8, 5, 6);
        finish_idle();

        // Base wrap modulo 2^IDX_W.
        run_model_job(250, 200, 9);
        finish_idle();

        for (int j = 0; j < 40; j++) begin
            run_model_job($urandom_range(0, 255) % ((j % 5 == 0) ? 3 : 256),
                          $urandom_range(0, 24), $urandom_range(0, 24));
            if ($urandom_range(0, 1) == 0) finish_idle();
        end
        finish_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
